exe_stage: RTL and testbench

Execute stage of the 5-stage MIPS pipeline. Consumes the decoded operands and control fields held in the ID/EXE pipeline register, computes the ALU result, and registers it toward EX/MEM. Divide and remainder run through an iterative unit. While that unit is busy, the stage asserts `stall` back to the hazard logic, which freezes the PC, IF/ID and ID/EXE.

---
 rtl/mips_pkg.sv | 37 +++
 rtl/divu_iter.sv | 83 ++++++++
 rtl/exe_stage.sv | 169 ++++++++++++++++
 tb/tb_exe_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: widths, execute-stage opcodes, divider states.
package mips_pkg;

  localparam int unsigned XlenDefault = 32;
  localparam int unsigned WbW         = 2;
  localparam int unsigned MemW        = 1;

  typedef enum logic [3:0] {
    CmdAdd  = 4'd0,
    CmdSub  = 4'd1,
    CmdAnd  = 4'd2,
    CmdOr   = 4'd3,
    CmdXor  = 4'd4,
    CmdNor  = 4'd5,
    CmdSlt  = 4'd6,
    CmdSltu = 4'd7,
    CmdSll  = 4'd8,
    CmdSrl  = 4'd9,
    CmdSra  = 4'd10,
    CmdLui  = 4'd11,
    CmdMul  = 4'd12,
    CmdDivu = 4'd13,
    CmdRemu = 4'd14,
    CmdRsvd = 4'd15
  } exe_cmd_e;

  typedef enum logic {
    StIdle,
    StDiv
  } div_state_e;

  // True for the commands that go through the iterative divider.
  function automatic logic is_div_cmd(input logic [3:0] cmd);
    return (cmd == CmdDivu) || (cmd == CmdRemu);
  endfunction

endpackage

// File: rtl/divu_iter.sv
// Unsigned restoring divider: one quotient bit per cycle, fixed XLEN-cycle latency.
// quotient/remainder are the values produced by the current step; they are final while done=1.
module divu_iter
  import mips_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            abort,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int unsigned CntW = $clog2(XLEN);

  div_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [XLEN-1:0] quo_q, rem_q, dvsr_q;
  logic [XLEN:0]   partial, diff;
  logic            fits, last;
  logic [XLEN-1:0] quo_step, rem_step;

  assign last = (cnt_q == CntW'(XLEN - 1));

  // One restoring step; a zero divisor always "fits", giving all-ones and rem = dividend.
  always_comb begin
    partial  = {rem_q, quo_q[XLEN-1]};
    diff     = partial - {1'b0, dvsr_q};
    fits     = ~diff[XLEN];
    quo_step = {quo_q[XLEN-2:0], fits};
    rem_step = fits ? diff[XLEN-1:0] : partial[XLEN-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start && !abort) state_d = StDiv;
      StDiv:  if (abort || last)   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy      = (state_q == StDiv);
    done      = busy && last;
    quotient  = quo_step;
    remainder = rem_step;
  end

  // Iteration datapath: load on start, shift/subtract while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else if (state_q == StIdle && start && !abort) begin
      quo_q  <= dividend;
      rem_q  <= '0;
      dvsr_q <= divisor;
      cnt_q  <= '0;
    end else if (busy) begin
      quo_q  <= quo_step;
      rem_q  <= rem_step;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand muxes, single-cycle ALU, iterative divide with upstream stall,
// and the EX/MEM output registers.
module exe_stage
  import mips_pkg::*;
#(
  parameter int unsigned XLEN   = XlenDefault,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [3:0]        exe_cmd,
  input  logic              imm_sel,
  input  logic              reg_dst,
  input  logic [MemW-1:0]   mem_in,
  input  logic [WbW-1:0]    wb_in,
  input  logic [XLEN-1:0]   read_data1,
  input  logic [XLEN-1:0]   read_data2,
  input  logic [XLEN-1:0]   sign_ex,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [REG_AW-1:0] dest1,
  input  logic [REG_AW-1:0] dest2,
  output logic              stall,
  output logic              out_valid,
  output logic [XLEN-1:0]   alu_result,
  output logic [XLEN-1:0]   store_data,
  output logic [XLEN-1:0]   pc_out,
  output logic [REG_AW-1:0] dest_out,
  output logic [MemW-1:0]   mem_out,
  output logic [WbW-1:0]    wb_out
);

  logic [XLEN-1:0]   op_a, op_b, alu;
  logic [4:0]        shamt;
  logic [REG_AW-1:0] dest_sel;
  logic              cmd_div;

  logic              div_start, div_busy, div_done;
  logic [XLEN-1:0]   div_quo, div_rem;

  // Set in the cycle the finished divide is presented; the same divide is still held in
  // ID/EXE then, so it must be retired instead of restarted.
  logic              div_done_q;

  logic              out_valid_q;
  logic [XLEN-1:0]   alu_q, store_q, pc_q;
  logic [REG_AW-1:0] dest_q;
  logic [MemW-1:0]   mem_q;
  logic [WbW-1:0]    wb_q;

  logic [XLEN-1:0]   lat_pc_q, lat_store_q;
  logic [REG_AW-1:0] lat_dest_q;
  logic [MemW-1:0]   lat_mem_q;
  logic [WbW-1:0]    lat_wb_q;
  logic              lat_rem_q;

  assign op_a     = read_data1;
  assign op_b     = imm_sel ? sign_ex : read_data2;
  assign shamt    = op_b[4:0];
  assign dest_sel = reg_dst ? dest2 : dest1;
  assign cmd_div  = is_div_cmd(exe_cmd);

  // Single-cycle ALU; divide opcodes yield 0 here since their result comes from the divider.
  always_comb begin
    alu = '0;
    case (exe_cmd_e'(exe_cmd))
      CmdAdd:  alu = op_a + op_b;
      CmdSub:  alu = op_a - op_b;
      CmdAnd:  alu = op_a & op_b;
      CmdOr:   alu = op_a | op_b;
      CmdXor:  alu = op_a ^ op_b;
      CmdNor:  alu = ~(op_a | op_b);
      CmdSlt:  alu = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      CmdSltu: alu = {{(XLEN-1){1'b0}}, op_a < op_b};
      CmdSll:  alu = op_a << shamt;
      CmdSrl:  alu = op_a >> shamt;
      CmdSra:  alu = $unsigned($signed(op_a) >>> shamt);
      CmdLui:  alu = op_b << 16;
      CmdMul:  alu = op_a * op_b;
      default: alu = '0;
    endcase
  end

  // Divider handshake and upstream stall.
  always_comb begin
    div_start = !rst && !flush && !div_busy && !div_done_q && in_valid && cmd_div;
    stall     = div_busy || (in_valid && cmd_div && !div_done_q);
  end

  divu_iter #(
    .XLEN (XLEN)
  ) u_divu_iter (
    .clk       (clk),
    .rst       (rst),
    .abort     (flush),
    .start     (div_start),
    .dividend  (op_a),
    .divisor   (op_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Output registers and divide side-band latch; rst beats flush beats normal operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      div_done_q  <= 1'b0;
      alu_q       <= '0;
      store_q     <= '0;
      pc_q        <= '0;
      dest_q      <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      lat_pc_q    <= '0;
      lat_store_q <= '0;
      lat_dest_q  <= '0;
      lat_mem_q   <= '0;
      lat_wb_q    <= '0;
      lat_rem_q   <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      div_done_q  <= 1'b0;
    end else if (div_busy) begin
      if (div_done) begin
        out_valid_q <= 1'b1;
        div_done_q  <= 1'b1;
        alu_q       <= lat_rem_q ? div_rem : div_quo;
        store_q     <= lat_store_q;
        pc_q        <= lat_pc_q;
        dest_q      <= lat_dest_q;
        mem_q       <= lat_mem_q;
        wb_q        <= lat_wb_q;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (div_done_q) begin
      out_valid_q <= 1'b0;
      div_done_q  <= 1'b0;
    end else if (in_valid && cmd_div) begin
      out_valid_q <= 1'b0;
      lat_pc_q    <= pc_in;
      lat_store_q <= read_data2;
      lat_dest_q  <= dest_sel;
      lat_mem_q   <= mem_in;
      lat_wb_q    <= wb_in;
      lat_rem_q   <= (exe_cmd == CmdRemu);
    end else begin
      out_valid_q <= in_valid;
      alu_q       <= alu;
      store_q     <= read_data2;
      pc_q        <= pc_in;
      dest_q      <= dest_sel;
      mem_q       <= mem_in;
      wb_q        <= wb_in;
    end
  end

  assign out_valid  = out_valid_q;
  assign alu_result = alu_q;
  assign store_data = store_q;
  assign pc_out     = pc_q;
  assign dest_out   = dest_q;
  assign mem_out    = mem_q;
  assign wb_out     = wb_q;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: the driver pushes expected results, the monitor pops on out_valid.
module tb_exe_stage;
  import mips_pkg::*;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, imm_sel, reg_dst;
  logic [3:0]        exe_cmd;
  logic [0:0]        mem_in;
  logic [1:0]        wb_in;
  logic [XLEN-1:0]   read_data1, read_data2, sign_ex, pc_in;
  logic [REG_AW-1:0] dest1, dest2;
  logic              stall, out_valid;
  logic [XLEN-1:0]   alu_result, store_data, pc_out;
  logic [REG_AW-1:0] dest_out;
  logic [0:0]        mem_out;
  logic [1:0]        wb_out;

  exe_stage #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .exe_cmd    (exe_cmd),
    .imm_sel    (imm_sel),
    .reg_dst    (reg_dst),
    .mem_in     (mem_in),
    .wb_in      (wb_in),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .sign_ex    (sign_ex),
    .pc_in      (pc_in),
    .dest1      (dest1),
    .dest2      (dest2),
    .stall      (stall),
    .out_valid  (out_valid),
    .alu_result (alu_result),
    .store_data (store_data),
    .pc_out     (pc_out),
    .dest_out   (dest_out),
    .mem_out    (mem_out),
    .wb_out     (wb_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] store;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [1:0]  wb;
    logic [0:0]  mem;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   seq   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every valid output must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out_valid: got result 0x%08h, expected no output (cycle %0d)",
                 alu_result, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("alu_result", alu_result, e.res);
        check("store_data", store_data, e.store);
        check("pc_out", pc_out, e.pc);
        check("dest_out", 32'(dest_out), 32'(e.dest));
        check("wb_out", 32'(wb_out), 32'(e.wb));
        check("mem_out", 32'(mem_out), 32'(e.mem));
        check("latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Drive one instruction, hold it while stalled, and count stall cycles.
  task automatic send(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                      input logic isel, input logic [31:0] imm, input logic [31:0] res);
    exp_t e;
    int   n;
    logic dv;
    dv         = (cmd == 4'd13) || (cmd == 4'd14);
    seq++;
    in_valid   = 1'b1;
    exe_cmd    = cmd;
    read_data1 = a;
    read_data2 = b;
    imm_sel    = isel;
    sign_ex    = imm;
    pc_in      = 32'h0040_0000 + 32'(seq * 4);
    dest1      = 5'(seq);
    dest2      = 5'(seq + 16);
    reg_dst    = seq[0];
    wb_in      = seq[1:0];
    mem_in     = seq[2:2];
    e.res      = res;
    e.store    = b;
    e.pc       = pc_in;
    e.dest     = reg_dst ? dest2 : dest1;
    e.wb       = wb_in;
    e.mem      = mem_in;
    e.cyc      = cyc + (dv ? 33 : 1);
    exp_q.push_back(e);
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      n++;
      if (n > 64) begin
        $display("FAIL stall_timeout: got %0d stall cycles, expected at most 33", n);
        n_bad++;
        break;
      end
      @(posedge clk);
      #1;
    end
    check(dv ? "stall_cycles_div" : "stall_cycles_single", 32'(n), dv ? 32'd33 : 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Present a divide without expecting a result (it will be aborted).
  task automatic present_div(input logic [31:0] a, input logic [31:0] b);
    in_valid   = 1'b1;
    exe_cmd    = 4'd13;
    read_data1 = a;
    read_data2 = b;
    imm_sel    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; exe_cmd = '0; imm_sel = 1'b0; reg_dst = 1'b0;
    mem_in = '0; wb_in = '0; read_data1 = '0; read_data2 = '0; sign_ex = '0; pc_in = '0;
    dest1 = '0; dest2 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_alu_result", alu_result, 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;

    // Single-cycle operations.
    send(CmdAdd,  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h0, 32'h8000_0000);
    send(CmdSub,  32'd5,         32'd7,         1'b0, 32'h0, 32'hFFFF_FFFE);
    send(CmdAnd,  32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'h0, 32'hF000_F000);
    send(CmdOr,   32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'h0, 32'hFFF0_FFF0);
    send(CmdXor,  32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'h0, 32'h0FF0_0FF0);
    send(CmdNor,  32'h0,         32'h0,         1'b0, 32'h0, 32'hFFFF_FFFF);
    send(CmdSlt,  32'hFFFF_FFFF, 32'h1,         1'b0, 32'h0, 32'h1);
    send(CmdSltu, 32'hFFFF_FFFF, 32'h1,         1'b0, 32'h0, 32'h0);
    send(CmdSll,  32'h1,         32'h1F,        1'b0, 32'h0, 32'h8000_0000);
    send(CmdSll,  32'h1,         32'h21,        1'b0, 32'h0, 32'h2);
    send(CmdSrl,  32'h8000_0000, 32'h4,         1'b0, 32'h0, 32'h0800_0000);
    send(CmdSra,  32'h8000_0000, 32'hDEAD,      1'b1, 32'h4, 32'hF800_0000);
    send(CmdLui,  32'h0,         32'h0,         1'b1, 32'h1234, 32'h1234_0000);
    send(CmdMul,  32'd3,         32'd5,         1'b0, 32'h0, 32'd15);
    send(CmdMul,  32'h0001_0000, 32'h0001_0001, 1'b0, 32'h0, 32'h0001_0000);
    send(CmdRsvd, 32'h1,         32'h2,         1'b0, 32'h0, 32'h0);

    // Divides, back to back, including divide by zero.
    send(CmdDivu, 32'd100, 32'd7, 1'b0, 32'h0, 32'd14);
    send(CmdRemu, 32'd100, 32'd7, 1'b0, 32'h0, 32'd2);
    send(CmdDivu, 32'd5,   32'd0, 1'b0, 32'h0, 32'hFFFF_FFFF);
    send(CmdRemu, 32'd5,   32'd0, 1'b0, 32'h0, 32'd5);
    send(CmdAdd,  32'd10,  32'd20, 1'b0, 32'h0, 32'd30);

    // Flush ten cycles into a divide.
    present_div(32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    flush    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_stall", 32'(stall), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    send(CmdAdd, 32'd2, 32'd3, 1'b0, 32'h0, 32'd5);

    // Reset in the middle of a divide.
    present_div(32'hFFFF_0000, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_alu_result", alu_result, 32'd0);
    check("rst_pc_out", pc_out, 32'd0);
    check("rst_sideband", {dest_out, wb_out, mem_out, store_data[0]}, 32'd0);
    @(posedge clk);
    #1;
    send(CmdAdd, 32'd3, 32'h0, 1'b1, 32'hFFFF_FFFE, 32'd1);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
